// File: rtl/dac_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dac_tx
//  Purpose  : Serial transmitter to an SPI-style DAC. Buffers 8-bit samples in
//             a small FIFO and sends each one as a 16-bit frame
//             {CTRL, sample, 4'b0000}, MSB first, framed by dac_cs_n.
//  Options  : DAC_LDAC_EN - adds dac_ldac_n, a 2-half-tick low pulse issued
//             after the inter-frame gap.
//  Revision : 1.0 - initial release
// ============================================================================
module dac_tx #(
    parameter int         CLK_DIV    = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] CTRL       = 4'b0011,
    parameter int         GAP_HT     = 4
) (
    input  logic       osc_clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       dac_sclk,
    output logic       dac_cs_n,
    output logic       dac_din,
    output logic       frame_done,
`ifdef DAC_LDAC_EN
    output logic       dac_ldac_n,
`endif
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP_HT > 1) ? $clog2(GAP_HT) : 1;

    // SETUP is the one half-tick between cs_n falling and the first sclk rise.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_LDAC  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Half-period divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic             half_tick;

    assign half_tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    // Free-running divider; wraps every CLK_DIV cycles.
    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n)       div_cnt_q <= '0;
        else if (half_tick) div_cnt_q <= '0;
        else                div_cnt_q <= div_cnt_q + DIV_W'(1);
    end

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, push, pop;
    state_t           state_q, state_d;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = half_tick && (state_q == ST_IDLE) && !empty;

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge osc_clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep count.
    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        din_q, din_d;
    logic        fd_q, fd_d;
    logic [14:0] shreg_q, shreg_d;   // bits still to send after the current one
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] frame_w;
`ifdef DAC_LDAC_EN
    logic        ldac_n_q, ldac_n_d;
`endif

    assign frame_w = {CTRL, mem_q[rd_ptr_q], 4'b0000};

    // State and output registers.
    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            din_q     <= 1'b0;
            fd_q      <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
`ifdef DAC_LDAC_EN
            ldac_n_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            din_q     <= din_d;
            fd_q      <= fd_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef DAC_LDAC_EN
            ldac_n_q  <= ldac_n_d;
`endif
        end
    end

    // Next-state logic; everything advances only on a half-tick.
    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        din_d     = din_q;
        fd_d      = 1'b0;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
`ifdef DAC_LDAC_EN
        ldac_n_d  = ldac_n_q;
`endif
        if (half_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        shreg_d   = frame_w[14:0];
                        din_d     = frame_w[15];
                        cs_n_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_SETUP;
                    end
                end
                ST_SETUP: state_d = ST_SHIFT;
                ST_SHIFT: begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q != 4'd15) begin
                            din_d     = shreg_q[14];
                            shreg_d   = {shreg_q[13:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                            cs_n_d    = 1'b1;
                            din_d     = 1'b0;
                            fd_d      = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_HT - 1)) begin
                        gap_cnt_d = '0;
`ifdef DAC_LDAC_EN
                        ldac_n_d  = 1'b0;
                        state_d   = ST_LDAC;
`else
                        state_d   = ST_IDLE;
`endif
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
`ifdef DAC_LDAC_EN
                ST_LDAC: begin
                    if (gap_cnt_q == GAP_W'(1)) begin
                        ldac_n_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign dac_sclk   = sclk_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_din    = din_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != ST_IDLE) || !empty;
`ifdef DAC_LDAC_EN
    assign dac_ldac_n = ldac_n_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dac_tx
//  Purpose  : Self-checking bench for dac_tx (CLK_DIV=4, GAP_HT=4, depth 4).
//             A frame-position model predicts every output each cycle;
//             directed scenarios add literal expectations.
//  Options  : DAC_LDAC_EN - also checks dac_ldac_n.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dac_tx;
    localparam int         CLK_DIV = 4;
    localparam int         GAP_HT  = 4;
    localparam int         DEPTH   = 4;
    localparam logic [3:0] CTRL    = 4'b0011;
`ifdef DAC_LDAC_EN
    localparam int EXTRA      = 2;
    localparam int PERIOD_CYC = 160;
`else
    localparam int EXTRA      = 0;
    localparam int PERIOD_CYC = 152;
`endif
    localparam int END_POS = 33 + GAP_HT + EXTRA;

    logic       osc_clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, dac_sclk, dac_cs_n, dac_din, frame_done, busy;
`ifdef DAC_LDAC_EN
    logic       dac_ldac_n;
`endif

    dac_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .CTRL(CTRL), .GAP_HT(GAP_HT)) dut (
        .osc_clk   (osc_clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .dac_sclk  (dac_sclk),
        .dac_cs_n  (dac_cs_n),
        .dac_din   (dac_din),
        .frame_done(frame_done),
`ifdef DAC_LDAC_EN
        .dac_ldac_n(dac_ldac_n),
`endif
        .busy      (busy)
    );

    always #5 osc_clk = ~osc_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a frame is described by how many half-ticks have passed since
    // it was loaded; all outputs follow from that position.
    // ------------------------------------------------------------------
    int          m_div = 0;
    bit          m_active = 0;
    int          m_pos = 0;
    bit          m_fd = 0;
    bit          m_pushed = 0;
    logic [15:0] m_word = '0;
    logic [7:0]  m_q[$];
    logic [15:0] m_exp_words[$];

    always @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            if (m_active && m_pos <= 32 && m_exp_words.size() > 0) void'(m_exp_words.pop_back());
            m_div = 0; m_active = 0; m_pos = 0; m_fd = 0; m_pushed = 0;
            m_q.delete();
        end else begin
            bit         half, can_push;
            logic [7:0] d;
            half     = (m_div == CLK_DIV - 1);
            m_div    = (m_div + 1) % CLK_DIV;
            can_push = in_valid && (m_q.size() < DEPTH);
            d        = in_data;
            m_fd     = 0;
            if (half) begin
                if (m_active) begin
                    m_pos++;
                    if (m_pos == 33) m_fd = 1;
                    if (m_pos == END_POS) m_active = 0;
                end else if (m_q.size() > 0) begin
                    m_word   = {CTRL, m_q.pop_front(), 4'h0};
                    m_exp_words.push_back(m_word);
                    m_active = 1;
                    m_pos    = 0;
                end
            end
            m_pushed = can_push;
            if (can_push) m_q.push_back(d);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge osc_clk) begin
        logic e_cs, e_sclk, e_din;
        int   k;
        e_cs   = !(m_active && m_pos <= 32);
        e_sclk = m_active && m_pos >= 2 && m_pos <= 32 && (m_pos % 2 == 0);
        k      = (m_pos <= 1) ? 0 : (m_pos - 1) / 2;
        e_din  = (m_active && m_pos <= 32) ? m_word[15 - k] : 1'b0;
        check("cs_n", dac_cs_n, e_cs);
        check("sclk", dac_sclk, e_sclk);
        check("din", dac_din, e_din);
        check("frame_done", frame_done, m_fd);
        check("busy", busy, m_active || m_q.size() > 0);
        check("in_ready", in_ready, m_q.size() < DEPTH);
`ifdef DAC_LDAC_EN
        check("ldac_n", dac_ldac_n,
              !(m_active && m_pos >= 33 + GAP_HT && m_pos < 33 + GAP_HT + 2));
`endif
    end

    // ------------------------------------------------------------------
    // Wire monitor: reassemble frames as the DAC would see them.
    // ------------------------------------------------------------------
    int          sbits = 0;
    logic [15:0] sh = '0;
    logic [15:0] cap[$];
    time         starts[$];
    time         fall_t = 0, rise_t = 0;
    int          low_cyc = 0;
    int          fd_count = 0;

    always @(negedge dac_cs_n) begin
        sbits = 0;
        fall_t = $time;
        starts.push_back($time);
    end
    always @(posedge dac_sclk) begin
        sh = {sh[14:0], dac_din};
        sbits++;
    end
    always @(posedge dac_cs_n) begin
        rise_t = $time;
        if (reset_n && sbits == 16) begin
            cap.push_back(sh);
            low_cyc = int'((rise_t - fall_t) / 10);
        end
    end
    always @(posedge osc_clk) if (frame_done === 1'b1) fd_count++;

`ifdef DAC_LDAC_EN
    time ldac_fall = 0;
    int  ldac_low = 0, ldac_delay = 0;
    always @(negedge dac_ldac_n) begin
        ldac_fall  = $time;
        ldac_delay = int'((ldac_fall - rise_t) / 10);
    end
    always @(posedge dac_ldac_n) if (reset_n) ldac_low = int'(($time - ldac_fall) / 10);
`endif

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge osc_clk);
        #1;
    endtask

    task automatic push_stream(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            int budget;
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            budget   = 0;
            do begin
                tick(1);
                budget++;
            end while (!m_pushed && budget < 2000);
            if (!m_pushed) check("push_timeout", 1, 0);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        while ((m_active || m_q.size() > 0) && budget < 5000) begin
            tick(1);
            budget++;
        end
        if (budget >= 5000) check("idle_timeout", 1, 0);
        tick(4);
    endtask

    task automatic check_frames();
        check("nframes", cap.size(), m_exp_words.size());
        for (int i = 0; i < cap.size() && i < m_exp_words.size(); i++)
            check("frame_word", cap[i], m_exp_words[i]);
        cap.delete();
        m_exp_words.delete();
        starts.delete();
    endtask

    initial begin
        int fd0, budget;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick(3);
        @(negedge osc_clk);
        check("rst_cs_n", dac_cs_n, 1);
        check("rst_sclk", dac_sclk, 0);
        check("rst_din", dac_din, 0);
        check("rst_fd", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        tick(1);
        reset_n = 1'b1;
        tick(3);

        // 1: single sample 0xA5
        fd0 = fd_count;
        push_stream(1, 8'hA5);
        wait_idle();
        check("t1_count", cap.size(), 1);
        if (cap.size() > 0) check("t1_word", cap[0], 16'h3A50);
        check("t1_cs_low", low_cyc, 132);
        check("t1_fd", fd_count - fd0, 1);
        check_frames();

        // 2: six samples back to back
        push_stream(6, 8'h10);
        wait_idle();
        check("t2_count", cap.size(), 6);
        for (int i = 0; i < cap.size(); i++) check("t2_word", cap[i], {CTRL, 8'h10 + 8'(i), 4'h0});
        for (int i = 1; i < starts.size(); i++)
            check("t2_period", int'((starts[i] - starts[i-1]) / 10), PERIOD_CYC);
`ifdef DAC_LDAC_EN
        check("ldac_low", ldac_low, 8);
        check("ldac_delay", ldac_delay, 16);
`endif
        check_frames();

        // 3: keep offering while full so pushes collide with pops
        push_stream(7, 8'hF0);
        wait_idle();
        check("t3_count", cap.size(), 7);
        for (int i = 0; i < cap.size(); i++) check("t3_word", cap[i], {CTRL, 8'hF0 + 8'(i), 4'h0});
        check_frames();

        // 4: reset in the middle of a frame
        fd0 = fd_count;
        push_stream(2, 8'h5A);
        budget = 0;
        while (!(dac_cs_n == 1'b0 && sbits == 8) && budget < 1000) begin
            tick(1);
            budget++;
        end
        check("t4_reach_bit7", sbits, 8);
        #1;
        reset_n = 1'b0;
        #1;
        check("t4_cs_n", dac_cs_n, 1);
        check("t4_sclk", dac_sclk, 0);
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("t4_busy", busy, 0);
        check("t4_in_ready", in_ready, 1);
        check("t4_fd", fd_count - fd0, 0);
        check("t4_count", cap.size(), 0);
        check_frames();
        tick(200);

        // 5: one frame then quiet
        push_stream(1, 8'h81);
        wait_idle();
        tick(20);
        check("t5_sclk", dac_sclk, 0);
        check("t5_cs_n", dac_cs_n, 1);
        check("t5_din", dac_din, 0);
        check("t5_busy", busy, 0);
        check("t5_count", cap.size(), 1);
        if (cap.size() > 0) check("t5_word", cap[0], 16'h3810);
        check_frames();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
